// File: rtl/ddr_axi_master.sv
// ============================================================================
// Module   : ddr_axi_master
// Function : single-burst AXI4 master bridging a simple command/beat-stream
//            interface to a DDR controller AXI slave port.
// Option   : DDR_AXI_MASTER_ERRCNT_EN builds the saturating err_count register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ddr_axi_master #(
  parameter int unsigned AXI_ID     = 0,
  parameter int unsigned ADDR_WIDTH = 28,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  // command
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_we,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [7:0]                cmd_len,
  // write-beat stream
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic [DATA_WIDTH/8-1:0]   wr_strb,
  // read-beat stream
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      rd_last,
  // completion
  output logic                      done,
  output logic                      done_err,
  output logic [7:0]                err_count,
  // AXI write address
  output logic [3:0]                ddr_awid,
  output logic [ADDR_WIDTH-1:0]     ddr_awaddr,
  output logic [7:0]                ddr_awlen,
  output logic [2:0]                ddr_awsize,
  output logic [1:0]                ddr_awburst,
  output logic                      ddr_awlock,
  output logic [3:0]                ddr_awcache,
  output logic [2:0]                ddr_awprot,
  output logic [3:0]                ddr_awqos,
  output logic                      ddr_awvalid,
  input  logic                      ddr_awready,
  // AXI write data
  output logic [DATA_WIDTH-1:0]     ddr_wdata,
  output logic [DATA_WIDTH/8-1:0]   ddr_wstrb,
  output logic                      ddr_wlast,
  output logic                      ddr_wvalid,
  input  logic                      ddr_wready,
  // AXI write response
  input  logic [3:0]                ddr_bid,
  input  logic [1:0]                ddr_bresp,
  input  logic                      ddr_bvalid,
  output logic                      ddr_bready,
  // AXI read address
  output logic [3:0]                ddr_arid,
  output logic [ADDR_WIDTH-1:0]     ddr_araddr,
  output logic [7:0]                ddr_arlen,
  output logic [2:0]                ddr_arsize,
  output logic [1:0]                ddr_arburst,
  output logic                      ddr_arlock,
  output logic [3:0]                ddr_arcache,
  output logic [2:0]                ddr_arprot,
  output logic [3:0]                ddr_arqos,
  output logic                      ddr_arvalid,
  input  logic                      ddr_arready,
  // AXI read data
  input  logic [3:0]                ddr_rid,
  input  logic [DATA_WIDTH-1:0]     ddr_rdata,
  input  logic [1:0]                ddr_rresp,
  input  logic                      ddr_rlast,
  input  logic                      ddr_rvalid,
  output logic                      ddr_rready
);

  localparam logic [3:0] c_axi_id = AXI_ID[3:0];

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WADDR = 3'd1;
  localparam logic [2:0] S_WDATA = 3'd2;
  localparam logic [2:0] S_WRESP = 3'd3;
  localparam logic [2:0] S_RADDR = 3'd4;
  localparam logic [2:0] S_RDATA = 3'd5;

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  rerr_q, rerr_d;
  logic                  done_q, done_d;
  logic                  done_err_q, done_err_d;

  logic w_cmd_fire, w_aw_fire, w_w_fire, w_b_fire, w_ar_fire, w_r_fire;
  logic w_b_err, w_r_beat_err;

  assign w_cmd_fire   = (state_q == S_IDLE)  && cmd_valid;
  assign w_aw_fire    = (state_q == S_WADDR) && ddr_awready;
  assign w_w_fire     = (state_q == S_WDATA) && wr_valid && ddr_wready;
  assign w_b_fire     = (state_q == S_WRESP) && ddr_bvalid;
  assign w_ar_fire    = (state_q == S_RADDR) && ddr_arready;
  assign w_r_fire     = (state_q == S_RDATA) && ddr_rvalid && rd_ready;
  // Only the SLVERR/DECERR bit matters; a foreign ID is also treated as an error.
  assign w_b_err      = ddr_bresp[1] || (ddr_bid != c_axi_id);
  assign w_r_beat_err = ddr_rresp[1] || (ddr_rid != c_axi_id);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (w_cmd_fire) state_d = cmd_we ? S_WADDR : S_RADDR;
      S_WADDR: if (w_aw_fire) state_d = S_WDATA;
      S_WDATA: if (w_w_fire && (cnt_q == 8'd0)) state_d = S_WRESP;
      S_WRESP: if (w_b_fire) state_d = S_IDLE;
      S_RADDR: if (w_ar_fire) state_d = S_RDATA;
      S_RDATA: if (w_r_fire && ddr_rlast) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready   = (state_q == S_IDLE);
    ddr_awvalid = (state_q == S_WADDR);
    ddr_wvalid  = (state_q == S_WDATA) && wr_valid;
    wr_ready    = (state_q == S_WDATA) && ddr_wready;
    ddr_wlast   = (state_q == S_WDATA) && (cnt_q == 8'd0);
    ddr_bready  = (state_q == S_WRESP);
    ddr_arvalid = (state_q == S_RADDR);
    rd_valid    = (state_q == S_RDATA) && ddr_rvalid;
    ddr_rready  = (state_q == S_RDATA) && rd_ready;
    rd_last     = (state_q == S_RDATA) && ddr_rlast;
  end

  // ---------------------------------------------------------------- datapath
  always_comb begin
    addr_d     = addr_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    rerr_d     = rerr_q;
    done_d     = 1'b0;
    done_err_d = 1'b0;
    if (w_cmd_fire) begin
      addr_d = {cmd_addr[ADDR_WIDTH-1:2], 2'b00};
      len_d  = cmd_len;
      rerr_d = 1'b0;
    end
    if (w_aw_fire) cnt_d = len_q;
    if (w_w_fire)  cnt_d = cnt_q - 8'd1;
    if (w_r_fire)  rerr_d = rerr_q | w_r_beat_err;
    if (w_b_fire) begin
      done_d     = 1'b1;
      done_err_d = w_b_err;
    end
    if (w_r_fire && ddr_rlast) begin
      done_d     = 1'b1;
      done_err_d = rerr_q | w_r_beat_err;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      rerr_q     <= 1'b0;
      done_q     <= 1'b0;
      done_err_q <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      rerr_q     <= rerr_d;
      done_q     <= done_d;
      done_err_q <= done_err_d;
    end
  end

  assign done     = done_q;
  assign done_err = done_err_q;

`ifdef DDR_AXI_MASTER_ERRCNT_EN
  logic [7:0] errcnt_q, errcnt_d;

  always_comb begin
    errcnt_d = errcnt_q;
    if (done_q && done_err_q && (errcnt_q != 8'hFF)) errcnt_d = errcnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      errcnt_q <= '0;
    end else begin
      errcnt_q <= errcnt_d;
    end
  end

  assign err_count = errcnt_q;
`else
  assign err_count = 8'd0;
`endif

  // ---------------------------------------------------------------- AXI fields
  assign ddr_awid    = c_axi_id;
  assign ddr_awaddr  = addr_q;
  assign ddr_awlen   = len_q;
  assign ddr_awsize  = 3'b010;
  assign ddr_awburst = 2'b01;
  assign ddr_awlock  = 1'b0;
  assign ddr_awcache = 4'b0011;
  assign ddr_awprot  = 3'b000;
  assign ddr_awqos   = 4'b0000;

  assign ddr_wdata   = wr_data;
  assign ddr_wstrb   = wr_strb;

  assign ddr_arid    = c_axi_id;
  assign ddr_araddr  = addr_q;
  assign ddr_arlen   = len_q;
  assign ddr_arsize  = 3'b010;
  assign ddr_arburst = 2'b01;
  assign ddr_arlock  = 1'b0;
  assign ddr_arcache = 4'b0011;
  assign ddr_arprot  = 3'b000;
  assign ddr_arqos   = 4'b0000;

  assign rd_data     = ddr_rdata;

  logic w_unused_ok;
  assign w_unused_ok = ^{cmd_addr[1:0], ddr_bresp[0], ddr_rresp[0]};

endmodule

`default_nettype wire

// File: doc/ddr_axi_master.md
DDR_AXI_MASTER -- requirements
Module: ddr_axi_master

Interface
REQ-001 Parameter AXI_ID, default 0: value driven on ddr_awid/ddr_arid and expected on ddr_bid/ddr_rid.
REQ-002 Parameter ADDR_WIDTH, default 28: byte-address width.
REQ-003 Parameter DATA_WIDTH, default 32: beat width; the block SHALL support only 32.
REQ-004 clk  in  1  single clock for all logic.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 cmd_valid/cmd_ready  in/out  1/1  command handshake.
REQ-007 cmd_we  in  1  1 = write burst, 0 = read burst.
REQ-008 cmd_addr  in  ADDR_WIDTH  start byte address.
REQ-009 cmd_len  in  8  beats minus one (AXI encoding).
REQ-010 wr_valid/wr_ready, wr_data, wr_strb  in/out, in, in  1/1, 32, 4  write-beat stream.
REQ-011 rd_valid/rd_ready, rd_data, rd_last  out/in, out, out  1/1, 32, 1  read-beat stream.
REQ-012 done, done_err  out  1, 1  completion pulse and error flag.
REQ-013 err_count  out  8  saturating error count (see Configuration).
REQ-014 ddr_aw*, ddr_w*, ddr_b*, ddr_ar*, ddr_r*  AXI4 master ports; widths: id 4, addr ADDR_WIDTH, len 8, size 3, burst 2, cache 4, prot 3, qos 4, data 32, strb 4, resp 2.

Function
REQ-015 States: IDLE, WADDR, WDATA, WRESP, RADDR, RDATA.
REQ-016 cmd_ready SHALL be 1 only in IDLE; on the handshake, capture addr (bits [1:0] forced to 0), len and we, and go to WADDR if we=1, else RADDR.
REQ-017 Constants: size=3'b010, burst=2'b01 (INCR), cache=4'b0011, prot=0, qos=0, lock=0, id=AXI_ID.
REQ-018 WADDR: ddr_awvalid=1 with stable addr/len until ddr_awready; then go to WDATA and load the beat counter with len.
REQ-019 The AW handshake SHALL complete before the first W beat; W is never issued concurrently with AW.
REQ-020 WDATA: ddr_wvalid=wr_valid, wr_ready=ddr_wready, data/strb pass through combinationally.
REQ-021 ddr_wlast=1 when the counter is 0; each accepted beat decrements the counter; after the last beat, go to WRESP.
REQ-022 WRESP: ddr_bready=1; on ddr_bvalid, error = bresp[1] OR (bid!=AXI_ID); return to IDLE.
REQ-023 RADDR: ddr_arvalid=1 with stable addr/len until ddr_arready; then go to RDATA.
REQ-024 RDATA: rd_valid=ddr_rvalid, ddr_rready=rd_ready, rd_data=ddr_rdata, rd_last=ddr_rlast.
REQ-025 Read error = OR over all beats of rresp[1] OR (rid!=AXI_ID); the accumulator clears on command accept.
REQ-026 Leave RDATA on the beat handshake with ddr_rlast=1; the counter is not used to end reads.
REQ-027 done SHALL pulse for exactly one cycle, the cycle after the final B or R handshake; done_err is valid with done and 0 otherwise.
REQ-028 Latency: cmd handshake at cycle N gives awvalid/arvalid at N+1; minimum write of one beat is 4 cycles to done with zero-wait slave.
REQ-029 wr_ready=0 outside WDATA; rd_valid=0 outside RDATA.
REQ-030 cmd_len=0 gives a single beat with wlast on that beat.
REQ-031 Commands crossing a 4 KiB boundary are caller error; they are issued unchanged.

Reset
REQ-032 rst asynchronously forces IDLE, clears the counter, error accumulator and err_count; done=0, all AXI valid/ready outputs=0.
REQ-033 rst mid-burst abandons the transaction; the slave is reset by the same system reset.

Configuration
REQ-034 Macro DDR_AXI_MASTER_ERRCNT_EN defined: err_count increments by one (saturating at 255) in each cycle done=1 with done_err=1.
REQ-035 Macro undefined: err_count is tied to 0 and no counter register is built.

Verification
REQ-036 Write cmd addr=0x100, len=3, wr_data 0xA0..0xA3, zero-wait slave -> awaddr=0x100, awlen=3, 4 W beats, wlast on 0xA3, done=1 with done_err=0.
REQ-037 Read cmd addr=0x203, len=0 -> araddr=0x200, one beat, rd_last=1, done pulse one cycle after the R handshake.
REQ-038 Write with awready delayed 5 cycles and random wready/wr_valid gaps -> awaddr/awlen stable while waiting, no W beat before the AW handshake, beat count exactly len+1.
REQ-039 Read len=7, beat 4 rresp=2'b10 -> all 8 beats delivered, done_err=1; err_count=1 with macro, 0 without.
REQ-040 rst pulse during WDATA beat 2 -> all valids 0 immediately, state IDLE, cmd_ready=1 in the first cycle after rst release.
REQ-041 bid=AXI_ID+1 with bresp=OKAY -> done_err=1.
